// File: rtl/imem_loader.sv
// Boot loader: consumes a length-prefixed little-endian byte stream and writes it
// into instruction memory, holding the core in reset until the last word lands.
module imem_loader #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_reset,
   output logic              load_done,
   output logic              load_err
);

   typedef enum logic [2:0] {HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   state_t              state_reg, state_next;
   logic [7:0]          n_lo_reg;
   logic [ADDR_W:0]     n_reg;
   logic [ADDR_W:0]     idx_reg;
   logic [1:0]          lane_reg;
   logic [DATA_W-1:0]   asm_reg;
   logic [DATA_W-1:0]   asm_next;
   logic [ADDR_W-1:0]   addr_reg;
   logic [DATA_W-1:0]   wdata_reg;

   logic                xfer;
   logic [16:0]         n_full;
   logic                hdr_bad;
   logic                last_word;

   assign xfer      = byte_valid && byte_ready;
   assign n_full    = {1'b0, byte_data, n_lo_reg};
   assign hdr_bad   = (n_full == 17'd0) || (n_full > DEPTH);
   assign last_word = (idx_reg == n_reg - (ADDR_W+1)'(1));

   // Byte steering into the assembly register, one lane per byte position.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign asm_next[8*gi +: 8] = (state_reg == DATA && xfer && lane_reg == 2'(gi))
                                      ? byte_data : asm_reg[8*gi +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= HDR0;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         HDR0:    if (xfer) state_next = HDR1;
         HDR1:    if (xfer) state_next = hdr_bad ? ERR : DATA;
         DATA:    if (xfer && lane_reg == 2'd3) state_next = WRITE;
         WRITE:   state_next = last_word ? DONE : DATA;
         DONE:    state_next = DONE;
         ERR:     state_next = ERR;
         default: state_next = HDR0;
      endcase
   end

   always_comb begin
      byte_ready = (state_reg == HDR0) || (state_reg == HDR1) || (state_reg == DATA);
      // Gated by reset so an abort landing on the WRITE cycle never commits.
      imem_we    = (state_reg == WRITE) && !reset;
      core_reset = (state_reg != DONE);
      load_done  = (state_reg == DONE);
      load_err   = (state_reg == ERR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         n_lo_reg  <= '0;
         n_reg     <= '0;
         idx_reg   <= '0;
         lane_reg  <= '0;
         asm_reg   <= '0;
         addr_reg  <= '0;
         wdata_reg <= '0;
      end else begin
         case (state_reg)
            HDR0: if (xfer) n_lo_reg <= byte_data;
            HDR1: if (xfer) begin
               n_reg    <= n_full[ADDR_W:0];
               idx_reg  <= '0;
               lane_reg <= '0;
            end
            DATA: if (xfer) begin
               lane_reg <= lane_reg + 2'd1;
               asm_reg  <= asm_next;
               // Capture the write operands as the fourth byte lands; they then hold.
               if (lane_reg == 2'd3) begin
                  addr_reg  <= idx_reg[ADDR_W-1:0];
                  wdata_reg <= asm_next;
               end
            end
            WRITE: if (!last_word) idx_reg <= idx_reg + (ADDR_W+1)'(1);
            default: ;
         endcase
      end
   end

   assign imem_addr  = addr_reg;
   assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header handling, word assembly, stalls,
// full-depth load, mid-load reset and write-cycle back-pressure.
module tb_imem_loader;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_wdata;
   logic              core_reset;
   logic              load_done;
   logic              load_err;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [DATA_W-1:0] wr_data_q[$];
   int                wr_cyc_q[$];

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor samples mid-cycle.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
         wr_cyc_q.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_cyc_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      byte_valid = 1'b0;
      byte_data = 8'h00;
      step();
      step();
      reset = 1'b0;
      clear_log();
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      byte_valid = 1'b1;
      byte_data = b;
      while (byte_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      vectors++;
      if (byte_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL send_byte_timeout: byte_ready=%b required 1 within 100 cycles", byte_ready);
      end
      step();
      byte_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic check_writes(input string name, input int exp_count,
                               input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0);
      vectors++;
      if (wr_addr_q.size() !== exp_count) begin
         miscompares++;
         $display("FAIL %s_count: got %0d writes, required %0d", name, wr_addr_q.size(), exp_count);
      end else if (exp_count > 0) begin
         vectors++;
         if (wr_addr_q[0] !== a0 || wr_data_q[0] !== d0) begin
            miscompares++;
            $display("FAIL %s_first: got addr %0d data %h, required addr %0d data %h",
                     name, wr_addr_q[0], wr_data_q[0], a0, d0);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (byte_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0 ||
          load_done !== 1'b0 || load_err !== 1'b0 || core_reset !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: got rdy=%b we=%b addr=%0d wdata=%h done=%b err=%b crst=%b, required 1 0 0 0 0 0 1",
                  byte_ready, imem_we, imem_addr, imem_wdata, load_done, load_err, core_reset);
      end
      $display("test_reset done");
   endtask

   task automatic test_single_word();
      do_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h0050_0513);
      vectors++;
      if (imem_we !== 1'b1 || imem_addr !== 9'd0 || imem_wdata !== 32'h0050_0513 || byte_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL single_write_cycle: got we=%b addr=%0d wdata=%h rdy=%b, required 1 0 00500513 0",
                  imem_we, imem_addr, imem_wdata, byte_ready);
      end
      vectors++;
      if (core_reset !== 1'b1 || load_done !== 1'b0) begin
         miscompares++;
         $display("FAIL single_core_held: got crst=%b done=%b, required 1 0", core_reset, load_done);
      end
      step();
      vectors++;
      if (load_done !== 1'b1 || core_reset !== 1'b0 || imem_we !== 1'b0 ||
          imem_addr !== 9'd0 || imem_wdata !== 32'h0050_0513) begin
         miscompares++;
         $display("FAIL single_done: got done=%b crst=%b we=%b addr=%0d wdata=%h, required 1 0 0 0 00500513",
                  load_done, core_reset, imem_we, imem_addr, imem_wdata);
      end
      check_writes("single", 1, 9'd0, 32'h0050_0513);
      $display("test_single_word done");
   endtask

   task automatic test_stall();
      logic [31:0] words[3];
      words[0] = 32'h1122_3344;
      words[1] = 32'hA5A5_5A5A;
      words[2] = 32'hDEAD_BEEF;
      do_reset();
      send_byte(8'h03); step(); send_byte(8'h00); step();
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 4; k++) begin
            send_byte(words[w][8*k +: 8]);
            step();
         end
      end
      check_writes("stall", 3, 9'd0, 32'h1122_3344);
      for (int w = 1; w < 3 && w < wr_addr_q.size(); w++) begin
         vectors++;
         if (wr_addr_q[w] !== ADDR_W'(w) || wr_data_q[w] !== words[w]) begin
            miscompares++;
            $display("FAIL stall_word%0d: got addr %0d data %h, required addr %0d data %h",
                     w, wr_addr_q[w], wr_data_q[w], w, words[w]);
         end
      end
      vectors++;
      if (load_done !== 1'b1 || core_reset !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_done: got done=%b crst=%b, required 1 0", load_done, core_reset);
      end
      $display("test_stall done");
   endtask

   task automatic test_bad_header(input logic [7:0] lo, input logic [7:0] hi);
      do_reset();
      send_byte(lo); send_byte(hi);
      byte_valid = 1'b1;
      byte_data = 8'h55;
      for (int i = 0; i < 8; i++) step();
      byte_valid = 1'b0;
      vectors++;
      if (load_err !== 1'b1 || byte_ready !== 1'b0 || core_reset !== 1'b1 || load_done !== 1'b0) begin
         miscompares++;
         $display("FAIL bad_header_%h%h: got err=%b rdy=%b crst=%b done=%b, required 1 0 1 0",
                  hi, lo, load_err, byte_ready, core_reset, load_done);
      end
      check_writes("bad_header", 0, '0, '0);
      $display("test_bad_header %h %h done", lo, hi);
   endtask

   task automatic test_full_depth();
      int bad;
      logic [31:0] w;
      do_reset();
      send_byte(8'h00); send_byte(8'h02);
      for (int i = 0; i < 512; i++) begin
         w = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
         send_word(w);
      end
      step();
      check_writes("full", 512, 9'd0, 32'hC0DE_0000);
      bad = 0;
      for (int i = 0; i < wr_addr_q.size(); i++) begin
         w = (32'(i) * 32'h0101_0101) ^ 32'hC0DE_0000;
         if (wr_addr_q[i] !== ADDR_W'(i) || wr_data_q[i] !== w) bad++;
      end
      vectors++;
      if (bad != 0) begin
         miscompares++;
         $display("FAIL full_contents: got %0d wrong writes, required 0", bad);
      end
      vectors++;
      if (load_done !== 1'b1 || imem_addr !== 9'd511) begin
         miscompares++;
         $display("FAIL full_done: got done=%b last addr=%0d, required 1 511", load_done, imem_addr);
      end
      byte_valid = 1'b1;
      byte_data = 8'hAA;
      for (int i = 0; i < 6; i++) step();
      byte_valid = 1'b0;
      vectors++;
      if (byte_ready !== 1'b0 || wr_addr_q.size() !== 512 || load_done !== 1'b1) begin
         miscompares++;
         $display("FAIL full_extra_bytes: got rdy=%b writes=%0d done=%b, required 0 512 1",
                  byte_ready, wr_addr_q.size(), load_done);
      end
      $display("test_full_depth done");
   endtask

   task automatic test_reset_mid_load();
      do_reset();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h0102_0304);
      step();
      send_byte(8'hEE); send_byte(8'hFF);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_writes("midreset_partial", 1, 9'd0, 32'h0102_0304);
      clear_log();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'hCAFE_F00D);
      step();
      check_writes("midreset_reload", 1, 9'd0, 32'hCAFE_F00D);
      // Reset landing on the WRITE cycle itself.
      do_reset();
      send_byte(8'h01); send_byte(8'h00);
      send_word(32'h1234_5678);
      reset = 1'b1;
      #1;
      vectors++;
      if (imem_we !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_in_write_we: got we=%b, required 0", imem_we);
      end
      step();
      reset = 1'b0;
      vectors++;
      if (wr_addr_q.size() !== 0 || imem_addr !== 9'd0 || imem_wdata !== 32'd0 || byte_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_write_state: got writes=%0d addr=%0d wdata=%h rdy=%b, required 0 0 0 1",
                  wr_addr_q.size(), imem_addr, imem_wdata, byte_ready);
      end
      $display("test_reset_mid_load done");
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_byte(8'h02); send_byte(8'h00);
      send_word(32'h8765_4321);
      byte_valid = 1'b1;
      byte_data = 8'h9A;
      vectors++;
      if (byte_ready !== 1'b0 || imem_we !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_write_stall: got rdy=%b we=%b, required 0 1", byte_ready, imem_we);
      end
      send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
      step();
      check_writes("b2b", 2, 9'd0, 32'h8765_4321);
      if (wr_addr_q.size() == 2) begin
         vectors++;
         if (wr_addr_q[1] !== 9'd1 || wr_data_q[1] !== 32'hF0DE_BC9A) begin
            miscompares++;
            $display("FAIL b2b_word1: got addr %0d data %h, required 1 f0debc9a", wr_addr_q[1], wr_data_q[1]);
         end
         vectors++;
         if (wr_cyc_q[1] - wr_cyc_q[0] !== 5) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d cycles between writes, required 5", wr_cyc_q[1] - wr_cyc_q[0]);
         end
      end
      $display("test_back_to_back done");
   endtask

   initial begin
      reset = 1'b1;
      byte_valid = 1'b0;
      byte_data = 8'h00;
      test_reset();
      test_single_word();
      test_stall();
      test_bad_header(8'h00, 8'h00);
      test_bad_header(8'h01, 8'h02);
      test_full_depth();
      test_reset_mid_load();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
